puf_keygen_engine: RTL and testbench

//  Parametrised PUF key-generation engine; successor to the fixed 256-bit PUF top.

---
 rtl/puf_keygen_engine.sv | 176 +++++++++++++++++
 tb/tb_puf_keygen_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_keygen_engine.sv
// PUF key-generation engine: scrambles a raw PUF response with a challenge-seeded Galois LFSR,
// then passes it through, enrolls a key (code-offset helper) or reconstructs one (repetition majority).
module puf_keygen_engine #(
  parameter int KEY_W = 128,
  parameter int REP = 3,
  parameter int LANES = 16,
  parameter int SEED_W = 8,
  parameter logic [SEED_W-1:0] POLY = 8'hB8,
  parameter int ERR_THR = 16,
  localparam int DATA_W = KEY_W * REP,
  localparam int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              PUF_Go,
  input  logic [1:0]        Op_Type,
  input  logic [SEED_W-1:0] Challenge_Seed,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] i_helper,
  input  logic [KEY_W-1:0]  key_in,
  output logic [DATA_W-1:0] data_out,
  output logic [KEY_W-1:0]  key_out,
  output logic [CNT_W-1:0]  err_count,
  output logic              PUF_Busy,
  output logic              PUF_Done,
  output logic              PUF_Err
);

  localparam int NCYC = KEY_W / LANES;
  localparam int CH = LANES * REP;
  localparam int CYC_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          op_reg;
  logic [SEED_W-1:0]   lfsr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   helper_reg;
  logic [KEY_W-1:0]    key_reg;
  logic [DATA_W-CH-1:0]   acc_data_reg;
  logic [KEY_W-LANES-1:0] acc_key_reg;
  logic [CNT_W-1:0]    acc_err_reg;
  logic [CYC_W-1:0]    cyc_reg;

  logic                last_cyc;
  logic [SEED_W-1:0]   lfsr_chain [0:CH];
  logic [CH-1:0]       stream;
  logic [CH-1:0]       r_chunk;
  logic [CH-1:0]       enr_chunk;
  logic [LANES-1:0]    maj;
  logic [LANES-1:0]    non_unan;
  logic [CH-1:0]       out_chunk;
  logic [LANES-1:0]    key_chunk;
  logic [CNT_W-1:0]    err_step;
  logic [DATA_W-1:0]   final_data;
  logic [KEY_W-1:0]    final_key;
  logic [CNT_W-1:0]    final_err;

  assign last_cyc = (cyc_reg == CYC_W'(NCYC - 1));
  assign PUF_Busy = (state_reg == S_LOAD) || (state_reg == S_PROC);
  assign PUF_Done = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (PUF_Go) state_next = (Op_Type == 2'd3) ? S_DONE : S_LOAD;
      S_LOAD: state_next = S_PROC;
      S_PROC: if (last_cyc) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One PROC cycle consumes CH stream bits: the LFSR is unrolled CH steps.
  assign lfsr_chain[0] = lfsr_reg;
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_lfsr
      assign stream[gi] = lfsr_chain[gi][0];
      assign lfsr_chain[gi+1] = (lfsr_chain[gi] >> 1) ^ (lfsr_chain[gi][0] ? POLY : '0);
    end
  endgenerate

  assign r_chunk = data_reg[CH-1:0] ^ stream;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [REP-1:0] vote;
      assign enr_chunk[gi*REP +: REP] = r_chunk[gi*REP +: REP] ^ {REP{key_reg[gi]}};
      assign vote = r_chunk[gi*REP +: REP] ^ helper_reg[gi*REP +: REP];
      assign maj[gi] = ($countones(vote) > (REP / 2));
      assign non_unan[gi] = (vote != '0) && (vote != {REP{1'b1}});
    end
  endgenerate

  always_comb begin
    out_chunk = '0;
    key_chunk = '0;
    err_step  = '0;
    case (op_reg)
      2'd0: out_chunk = r_chunk;
      2'd1: begin
        out_chunk = enr_chunk;
        key_chunk = key_reg[LANES-1:0];
      end
      2'd2: begin
        key_chunk = maj;
        err_step  = CNT_W'($countones(non_unan));
      end
      default: ;
    endcase
  end

  // Results fill from the top and shift down, so chunk 0 lands at bit 0 after NCYC cycles.
  assign final_data = {out_chunk, acc_data_reg};
  assign final_key  = {key_chunk, acc_key_reg};
  assign final_err  = acc_err_reg + err_step;

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_reg    <= S_IDLE;
      op_reg       <= '0;
      lfsr_reg     <= '0;
      data_reg     <= '0;
      helper_reg   <= '0;
      key_reg      <= '0;
      acc_data_reg <= '0;
      acc_key_reg  <= '0;
      acc_err_reg  <= '0;
      cyc_reg      <= '0;
      data_out     <= '0;
      key_out      <= '0;
      err_count    <= '0;
      PUF_Err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (PUF_Go) begin
            op_reg      <= Op_Type;
            data_reg    <= data_in;
            helper_reg  <= i_helper;
            key_reg     <= key_in;
            lfsr_reg    <= (Challenge_Seed == '0) ? '1 : Challenge_Seed;
            cyc_reg     <= '0;
            acc_err_reg <= '0;
            if (Op_Type == 2'd3) begin
              data_out  <= '0;
              key_out   <= '0;
              err_count <= '0;
              PUF_Err   <= 1'b1;
            end
          end
        end
        S_PROC: begin
          lfsr_reg     <= lfsr_chain[CH];
          data_reg     <= data_reg >> CH;
          helper_reg   <= helper_reg >> CH;
          key_reg      <= key_reg >> LANES;
          acc_data_reg <= final_data[DATA_W-1:CH];
          acc_key_reg  <= final_key[KEY_W-1:LANES];
          acc_err_reg  <= final_err;
          cyc_reg      <= cyc_reg + 1'b1;
          if (last_cyc) begin
            data_out  <= final_data;
            key_out   <= final_key;
            err_count <= final_err;
            PUF_Err   <= (op_reg == 2'd2) && (final_err > CNT_W'(ERR_THR));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_keygen_engine.sv
// Bench for puf_keygen_engine: a spec-level model predicts outputs and timing every cycle,
// and directed operations are also checked against hand-derived literals.
module tb_puf_keygen_engine;
  localparam int KEY_W = 128;
  localparam int REP = 3;
  localparam int LANES = 16;
  localparam int SEED_W = 8;
  localparam int ERR_THR = 16;
  localparam int DATA_W = KEY_W * REP;
  localparam int NCYC = KEY_W / LANES;
  localparam int CW = $clog2(KEY_W + 1);

  logic              clk = 1'b0;
  logic              Resetn = 1'b0;
  logic              PUF_Go = 1'b0;
  logic [1:0]        Op_Type = 2'd0;
  logic [SEED_W-1:0] Challenge_Seed = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] i_helper = '0;
  logic [KEY_W-1:0]  key_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [KEY_W-1:0]  key_out;
  logic [CW-1:0]     err_count;
  logic              PUF_Busy, PUF_Done, PUF_Err;

  always #5 clk = ~clk;

  puf_keygen_engine #(
    .KEY_W(KEY_W), .REP(REP), .LANES(LANES), .SEED_W(SEED_W),
    .POLY(8'hB8), .ERR_THR(ERR_THR)
  ) dut (
    .clk(clk), .Resetn(Resetn), .PUF_Go(PUF_Go), .Op_Type(Op_Type),
    .Challenge_Seed(Challenge_Seed), .data_in(data_in), .i_helper(i_helper),
    .key_in(key_in), .data_out(data_out), .key_out(key_out), .err_count(err_count),
    .PUF_Busy(PUF_Busy), .PUF_Done(PUF_Done), .PUF_Err(PUF_Err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Keystream straight from the LFSR definition, one bit per step.
  function automatic logic [DATA_W-1:0] model_stream(input logic [7:0] seed);
    logic [7:0] l;
    logic [DATA_W-1:0] s;
    l = (seed == 8'h00) ? 8'hFF : seed;
    s = '0;
    for (int j = 0; j < DATA_W; j++) begin
      s[j] = l[0];
      l = {1'b0, l[7:1]} ^ (s[j] ? 8'hB8 : 8'h00);
    end
    return s;
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [7:0] seed,
                          input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] help,
                          input logic [KEY_W-1:0] key,
                          output logic [DATA_W-1:0] d, output logic [KEY_W-1:0] k,
                          output logic [CW-1:0] e, output logic perr);
    logic [DATA_W-1:0] r;
    int ones, ne;
    r = din ^ model_stream(seed);
    d = '0; k = '0; ne = 0; perr = 1'b0;
    case (op)
      2'd0: d = r;
      2'd1: begin
        for (int g = 0; g < KEY_W; g++)
          for (int i = 0; i < REP; i++) d[g*REP+i] = r[g*REP+i] ^ key[g];
        k = key;
      end
      2'd2: begin
        for (int g = 0; g < KEY_W; g++) begin
          ones = 0;
          for (int i = 0; i < REP; i++) ones += int'(r[g*REP+i] ^ help[g*REP+i]);
          k[g] = (ones * 2 > REP);
          if (ones != 0 && ones != REP) ne++;
        end
        perr = (ne > ERR_THR);
      end
      default: perr = 1'b1;
    endcase
    e = CW'(ne);
  endtask

  function automatic logic [DATA_W-1:0] flips(input int n);
    logic [DATA_W-1:0] f;
    f = '0;
    for (int g = 0; g < n; g++) f[g*REP + (g % REP)] = 1'b1;
    return f;
  endfunction

  // Cycle-level expectation: an accepted Go at edge E gives Done after edge E+NCYC+1 (E for op 3).
  int edge_n = 0, go_edge = -10, done_edge = -10, accept_edge = 0;
  bit model_on = 1'b0;
  logic [DATA_W-1:0] exp_data = '0, pend_data;
  logic [KEY_W-1:0]  exp_key = '0, pend_key;
  logic [CW-1:0]     exp_err = '0, pend_err;
  logic              exp_perr = 1'b0, pend_perr, exp_done = 1'b0, exp_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    edge_n++;
    if (!Resetn) begin
      model_on = 1'b1;
      go_edge = -10; done_edge = -10; accept_edge = edge_n + 1;
      exp_data = '0; exp_key = '0; exp_err = '0; exp_perr = 1'b0;
    end else begin
      if (edge_n >= accept_edge && PUF_Go) begin
        model_op(Op_Type, Challenge_Seed, data_in, i_helper, key_in,
                 pend_data, pend_key, pend_err, pend_perr);
        go_edge = edge_n;
        done_edge = edge_n + ((Op_Type == 2'd3) ? 0 : NCYC + 1);
        accept_edge = done_edge + 2;
      end
      if (edge_n == done_edge) begin
        exp_data = pend_data; exp_key = pend_key; exp_err = pend_err; exp_perr = pend_perr;
      end
    end
    exp_done = (edge_n == done_edge);
    exp_busy = (edge_n >= go_edge) && (edge_n < done_edge);
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("cyc_done", PUF_Done, exp_done);
      chk("cyc_busy", PUF_Busy, exp_busy);
      chk("cyc_data", data_out, exp_data);
      chk("cyc_key", key_out, exp_key);
      chk("cyc_err_count", err_count, exp_err);
      chk("cyc_puf_err", PUF_Err, exp_perr);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [7:0] seed,
                        input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] help,
                        input logic [KEY_W-1:0] key, input int exp_lat, input string name);
    int cnt;
    Op_Type = op; Challenge_Seed = seed; data_in = din; i_helper = help; key_in = key;
    PUF_Go = 1'b1;
    @(negedge clk);
    PUF_Go = 1'b0;
    cnt = 1;
    while (!PUF_Done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_latency"}, DATA_W'(cnt), DATA_W'(exp_lat));
    @(negedge clk);
  endtask

  logic [DATA_W-1:0] md, md2, ms, pat, help_v;
  logic [KEY_W-1:0]  mk, key_c;
  logic [CW-1:0]     me;
  logic              mp;
  logic [7:0]        lo;
  int cnt, seen;

  initial begin
    key_c = {4{32'hDEADBEEF}};
    pat = {12{32'h3C5A_96E1}};
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_data", data_out, '0);
    chk("reset_done", PUF_Done, 1'b0);
    chk("reset_busy", PUF_Busy, 1'b0);
    Resetn = 1'b1;
    @(negedge clk);

    // Hand-stepped LFSR prefixes pin the model's keystream.
    ms = model_stream(8'h01); lo = ms[7:0];
    chk("model_seed01", lo, 8'h71);
    ms = model_stream(8'hFF); lo = ms[7:0];
    chk("model_seedFF", lo, 8'h2F);
    chk("model_seed00_eq_FF", model_stream(8'h00), ms);

    run_op(2'd0, 8'h00, '0, '0, '0, NCYC + 2, "op0_s00");
    lo = data_out[7:0];
    chk("op0_s00_lo", lo, 8'h2F);
    run_op(2'd0, 8'hFF, '0, '0, '0, NCYC + 2, "op0_sFF");
    chk("op0_sFF_eq_s00", data_out, model_stream(8'h00));
    run_op(2'd0, 8'hFF, '1, '0, '0, NCYC + 2, "op0_ones");
    chk("op0_ones_compl", data_out, ~model_stream(8'hFF));
    run_op(2'd0, 8'h01, '0, '0, '0, NCYC + 2, "op0_s01");
    lo = data_out[7:0];
    chk("op0_s01_lo", lo, 8'h71);

    model_op(2'd1, 8'h5A, pat, '0, key_c, help_v, mk, me, mp);
    run_op(2'd1, 8'h5A, pat, '0, key_c, NCYC + 2, "enroll");
    chk("enroll_helper", data_out, help_v);
    chk("enroll_key", key_out, key_c);
    chk("enroll_perr", PUF_Err, 1'b0);

    run_op(2'd2, 8'h5A, pat, help_v, '0, NCYC + 2, "recon_clean");
    chk("recon_clean_key", key_out, key_c);
    chk("recon_clean_err", err_count, 0);
    chk("recon_clean_perr", PUF_Err, 1'b0);
    chk("recon_clean_data", data_out, '0);

    run_op(2'd2, 8'h5A, pat ^ flips(128), help_v, '0, NCYC + 2, "recon_all");
    chk("recon_all_key", key_out, key_c);
    chk("recon_all_err", err_count, 128);
    chk("recon_all_perr", PUF_Err, 1'b1);

    run_op(2'd2, 8'h5A, pat ^ flips(16), help_v, '0, NCYC + 2, "recon_16");
    chk("recon_16_err", err_count, 16);
    chk("recon_16_perr", PUF_Err, 1'b0);
    chk("recon_16_key", key_out, key_c);
    run_op(2'd2, 8'h5A, pat ^ flips(17), help_v, '0, NCYC + 2, "recon_17");
    chk("recon_17_err", err_count, 17);
    chk("recon_17_perr", PUF_Err, 1'b1);

    run_op(2'd2, 8'h5A, pat ^ 384'h3, help_v, '0, NCYC + 2, "recon_2flip");
    chk("recon_2flip_key", key_out, key_c ^ 128'h1);
    chk("recon_2flip_err", err_count, 1);

    run_op(2'd3, 8'h12, pat, '0, key_c, 1, "illegal");
    chk("illegal_perr", PUF_Err, 1'b1);
    chk("illegal_data", data_out, '0);
    chk("illegal_key", key_out, '0);

    // A second Go while busy must be ignored.
    Op_Type = 2'd0; Challenge_Seed = 8'h01; data_in = '0;
    PUF_Go = 1'b1;
    @(negedge clk);
    PUF_Go = 1'b0; cnt = 1;
    repeat (2) begin @(negedge clk); cnt++; end
    Op_Type = 2'd3; Challenge_Seed = 8'h77; data_in = '1; PUF_Go = 1'b1;
    @(negedge clk);
    cnt++; PUF_Go = 1'b0;
    while (!PUF_Done && cnt < 60) begin @(negedge clk); cnt++; end
    chk("busy_go_latency", cnt, NCYC + 2);
    chk("busy_go_perr", PUF_Err, 1'b0);
    lo = data_out[7:0];
    chk("busy_go_lo", lo, 8'h71);
    @(negedge clk);

    // Reset in the middle of PROC aborts without a Done pulse.
    Op_Type = 2'd0; Challenge_Seed = 8'hFF; data_in = pat;
    PUF_Go = 1'b1;
    @(negedge clk);
    PUF_Go = 1'b0;
    repeat (3) @(negedge clk);
    Resetn = 1'b0;
    @(negedge clk);
    Resetn = 1'b1; seen = 0;
    repeat (15) begin @(negedge clk); if (PUF_Done) seen++; end
    chk("abort_no_done", seen, 0);
    chk("abort_data", data_out, '0);
    model_op(2'd0, 8'h33, pat, '0, '0, md, mk, me, mp);
    run_op(2'd0, 8'h33, pat, '0, '0, NCYC + 2, "after_abort");
    chk("after_abort_data", data_out, md);

    // Reset and Go in the same cycle: reset wins.
    Resetn = 1'b0; PUF_Go = 1'b1; Op_Type = 2'd0;
    @(negedge clk);
    PUF_Go = 1'b0; Resetn = 1'b1; seen = 0;
    repeat (12) begin @(negedge clk); if (PUF_Done || PUF_Busy) seen++; end
    chk("reset_go_idle", seen, 0);

    model_op(2'd0, 8'hFF, '1, '0, '0, md2, mk, me, mp);
    run_op(2'd0, 8'hFF, '1, '0, '0, NCYC + 2, "final");
    chk("final_data", data_out, md2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
